// File: rtl/pm_loader_pkg.sv
// Shared types and constants for the program-memory loader.
// The optional inter-byte timeout is enabled by defining PM_LOADER_TIMEOUT_EN.
package pm_loader_pkg;

   localparam int PM_AW = 8;
   localparam int PM_DW = 8;

   localparam logic [7:0] HDR_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LEN  = 3'd1,
      DATA = 3'd2,
      CSUM = 3'd3,
      DONE = 3'd4,
      ERR  = 3'd5
   } state_t;

   // Running 8-bit modular checksum step.
   function automatic logic [PM_DW-1:0] csum_add(input logic [PM_DW-1:0] acc,
                                                 input logic [PM_DW-1:0] b);
      return acc + b;
   endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: rx synchronizer, mid-bit sampling, byte_valid / frame_err pulses.
// start_det pulses whenever a falling edge starts a byte, including glitches.
module uart_rx_byte
   import pm_loader_pkg::*;
#(
   parameter int CLK_DIV = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] data,
   output logic       byte_valid,
   output logic       frame_err,
   output logic       start_det
);

   localparam int CW = $clog2(CLK_DIV + 1);
   localparam logic [CW-1:0] HALF = CW'(CLK_DIV / 2 - 1);
   localparam logic [CW-1:0] FULL = CW'(CLK_DIV - 1);

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_t;

   logic          rx_meta_r, rx_sync_r, rx_prev_r;
   rx_state_t     state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [2:0]    bit_r, bit_s;
   logic [7:0]    shift_r, shift_s;
   logic [7:0]    data_r, data_s;
   logic          valid_r, valid_s;
   logic          ferr_r, ferr_s;
   logic          sdet_r, sdet_s;

   // Two-flop synchronizer plus one delayed copy for edge detection; idle high.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rx_meta_r <= 1'b1;
         rx_sync_r <= 1'b1;
         rx_prev_r <= 1'b1;
      end else begin
         rx_meta_r <= rx;
         rx_sync_r <= rx_meta_r;
         rx_prev_r <= rx_sync_r;
      end
   end

   // Receiver state and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= RX_IDLE;
         cnt_r   <= CW'(0);
         bit_r   <= 3'd0;
         shift_r <= 8'd0;
         data_r  <= 8'd0;
         valid_r <= 1'b0;
         ferr_r  <= 1'b0;
         sdet_r  <= 1'b0;
      end else begin
         state_r <= state_s;
         cnt_r   <= cnt_s;
         bit_r   <= bit_s;
         shift_r <= shift_s;
         data_r  <= data_s;
         valid_r <= valid_s;
         ferr_r  <= ferr_s;
         sdet_r  <= sdet_s;
      end
   end

   // Bit timing: half a bit to the start-bit centre, then full bits between samples.
   always_comb begin
      state_s = state_r;
      cnt_s   = cnt_r;
      bit_s   = bit_r;
      shift_s = shift_r;
      data_s  = data_r;
      valid_s = 1'b0;
      ferr_s  = 1'b0;
      sdet_s  = 1'b0;
      case (state_r)
         RX_IDLE: begin
            if (rx_prev_r && !rx_sync_r) begin
               state_s = RX_START;
               cnt_s   = CW'(0);
               sdet_s  = 1'b1;
            end else begin
               state_s = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_r == HALF) begin
               cnt_s = CW'(0);
               bit_s = 3'd0;
               if (rx_sync_r) begin
                  state_s = RX_IDLE;
               end else begin
                  state_s = RX_DATA;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_r == FULL) begin
               cnt_s   = CW'(0);
               shift_s = {rx_sync_r, shift_r[7:1]};
               if (bit_r == 3'd7) begin
                  state_s = RX_STOP;
               end else begin
                  bit_s = bit_r + 3'd1;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_r == FULL) begin
               state_s = RX_IDLE;
               cnt_s   = CW'(0);
               if (rx_sync_r) begin
                  valid_s = 1'b1;
                  data_s  = shift_r;
               end else begin
                  ferr_s = 1'b1;
               end
            end else begin
               cnt_s = cnt_r + CW'(1);
            end
         end
         default: begin
            state_s = RX_IDLE;
         end
      endcase
   end

   assign data       = data_r;
   assign byte_valid = valid_r;
   assign frame_err  = ferr_r;
   assign start_det  = sdet_r;

endmodule

// File: rtl/pm_loader.sv
// Frame parser that writes a UART-delivered program image into program memory and holds the CPU.
// Define PM_LOADER_TIMEOUT_EN to abort frames that stall for TIMEOUT_BITS bit times.
module pm_loader
   import pm_loader_pkg::*;
#(
   parameter int         CLK_DIV      = 434,
   parameter logic [7:0] HDR_BYTE     = HDR_BYTE_DEF,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rx,
   output logic [PM_AW-1:0] pm_wr_addr,
   output logic [PM_DW-1:0] pm_wr_data,
   output logic             pm_wren,
   output logic             cpu_hold,
   output logic             load_done,
   output logic             load_err
);

   logic [7:0] rx_data_s;
   logic       rx_valid_s, rx_ferr_s, rx_sdet_s;
   logic       timeout_s;

   state_t           state_r, state_s;
   logic [PM_AW-1:0] addr_r, addr_s;
   logic [PM_DW-1:0] sum_r, sum_s;
   logic [8:0]       cnt_r, cnt_s;
   logic             wren_r, wren_s;
   logic [PM_AW-1:0] wr_addr_r, wr_addr_s;
   logic [PM_DW-1:0] wr_data_r, wr_data_s;
   logic             hold_r, hold_s;
   logic             done_r, done_s;
   logic             err_r, err_s;

   uart_rx_byte #(.CLK_DIV(CLK_DIV)) u_rx (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .data       (rx_data_s),
      .byte_valid (rx_valid_s),
      .frame_err  (rx_ferr_s),
      .start_det  (rx_sdet_s)
   );

`ifdef PM_LOADER_TIMEOUT_EN
   localparam int GAP_MAX = TIMEOUT_BITS * CLK_DIV;
   localparam int GW      = $clog2(GAP_MAX + 1);

   logic [GW-1:0] gap_r;
   logic          in_frame_s;

   assign in_frame_s = (state_r == LEN) || (state_r == DATA) || (state_r == CSUM);

   // Idle-gap counter, restarted by every start bit while a frame is open.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         gap_r <= GW'(0);
      end else if (!in_frame_s || rx_sdet_s) begin
         gap_r <= GW'(0);
      end else if (gap_r != GW'(GAP_MAX)) begin
         gap_r <= gap_r + GW'(1);
      end else begin
         gap_r <= gap_r;
      end
   end

   assign timeout_s = in_frame_s && (gap_r == GW'(GAP_MAX));
`else
   logic [1:0] unused_s;
   assign unused_s  = {rx_sdet_s, TIMEOUT_BITS[0]};
   assign timeout_s = 1'b0;
`endif

   // Frame FSM state, counters and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r   <= IDLE;
         addr_r    <= 8'd0;
         sum_r     <= 8'd0;
         cnt_r     <= 9'd0;
         wren_r    <= 1'b0;
         wr_addr_r <= 8'd0;
         wr_data_r <= 8'd0;
         hold_r    <= 1'b0;
         done_r    <= 1'b0;
         err_r     <= 1'b0;
      end else begin
         state_r   <= state_s;
         addr_r    <= addr_s;
         sum_r     <= sum_s;
         cnt_r     <= cnt_s;
         wren_r    <= wren_s;
         wr_addr_r <= wr_addr_s;
         wr_data_r <= wr_data_s;
         hold_r    <= hold_s;
         done_r    <= done_s;
         err_r     <= err_s;
      end
   end

   // Next-state logic; output flags are set on entry so they align with DONE/ERR.
   always_comb begin
      state_s   = state_r;
      addr_s    = addr_r;
      sum_s     = sum_r;
      cnt_s     = cnt_r;
      wren_s    = 1'b0;
      wr_addr_s = wr_addr_r;
      wr_data_s = wr_data_r;
      hold_s    = hold_r;
      done_s    = 1'b0;
      err_s     = err_r;
      case (state_r)
         IDLE: begin
            if (rx_valid_s && (rx_data_s == HDR_BYTE)) begin
               state_s = LEN;
               hold_s  = 1'b1;
               err_s   = 1'b0;
               addr_s  = 8'd0;
               sum_s   = 8'd0;
            end else begin
               state_s = IDLE;
            end
         end
         LEN: begin
            if (rx_ferr_s || timeout_s) begin
               state_s = ERR;
               err_s   = 1'b1;
            end else if (rx_valid_s) begin
               state_s = DATA;
               cnt_s   = (rx_data_s == 8'd0) ? 9'd256 : {1'b0, rx_data_s};
            end else begin
               state_s = LEN;
            end
         end
         DATA: begin
            if (rx_ferr_s || timeout_s) begin
               state_s = ERR;
               err_s   = 1'b1;
            end else if (rx_valid_s) begin
               wren_s    = 1'b1;
               wr_addr_s = addr_r;
               wr_data_s = rx_data_s;
               addr_s    = addr_r + 8'd1;
               sum_s     = csum_add(sum_r, rx_data_s);
               cnt_s     = cnt_r - 9'd1;
               state_s   = (cnt_r == 9'd1) ? CSUM : DATA;
            end else begin
               state_s = DATA;
            end
         end
         CSUM: begin
            if (rx_ferr_s || timeout_s) begin
               state_s = ERR;
               err_s   = 1'b1;
            end else if (rx_valid_s) begin
               if (csum_add(sum_r, rx_data_s) == 8'd0) begin
                  state_s = DONE;
                  done_s  = 1'b1;
                  hold_s  = 1'b0;
               end else begin
                  state_s = ERR;
                  err_s   = 1'b1;
               end
            end else begin
               state_s = CSUM;
            end
         end
         DONE: begin
            state_s = IDLE;
         end
         ERR: begin
            state_s = IDLE;
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   assign pm_wr_addr = wr_addr_r;
   assign pm_wr_data = wr_data_r;
   assign pm_wren    = wren_r;
   assign cpu_hold   = hold_r;
   assign load_done  = done_r;
   assign load_err   = err_r;

endmodule

// File: tb/tb_pm_loader.sv
// Self-checking bench for pm_loader: frame table, write scoreboard and corner-case sequences.
module tb_pm_loader;

   localparam int         CLK_DIV = 12;
   localparam logic [7:0] HDR     = 8'hA5;

   logic       clk;
   logic       reset;
   logic       rx;
   logic [7:0] pm_wr_addr;
   logic [7:0] pm_wr_data;
   logic       pm_wren;
   logic       cpu_hold;
   logic       load_done;
   logic       load_err;

   int errors = 0;
   int checks = 0;
   int done_cnt = 0;

   logic [15:0] exp_q[$];
   logic [15:0] exp_w;
   logic [7:0]  last_addr, last_data;

   int         m_st;
   logic [7:0] m_addr;
   int         m_cnt;

   typedef struct {
      int         n;
      logic [7:0] b[8];
      int         exp_done;
      logic       exp_err;
      logic       exp_hold;
   } frame_t;

   frame_t tbl[4];

   pm_loader #(.CLK_DIV(CLK_DIV), .HDR_BYTE(HDR), .TIMEOUT_BITS(20)) dut (
      .clk        (clk),
      .reset      (reset),
      .rx         (rx),
      .pm_wr_addr (pm_wr_addr),
      .pm_wr_data (pm_wr_data),
      .pm_wren    (pm_wren),
      .cpu_hold   (cpu_hold),
      .load_done  (load_done),
      .load_err   (load_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
      $fatal(1);
   end

   // Write scoreboard and done-pulse counter, sampled on the falling edge.
   always @(negedge clk) begin
      if (load_done) done_cnt++;
      if (pm_wren) begin
         checks++;
         last_addr = pm_wr_addr;
         last_data = pm_wr_data;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL wr_unexpected: got %h@%h, required no write", pm_wr_data, pm_wr_addr);
         end else begin
            exp_w = exp_q.pop_front();
            if ({pm_wr_addr, pm_wr_data} !== exp_w) begin
               errors++;
               $display("FAIL wr_value: got %h@%h, required %h@%h",
                        pm_wr_data, pm_wr_addr, exp_w[7:0], exp_w[15:8]);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, required %0h", name, act, exp);
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (CLK_DIV) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CLK_DIV) @(negedge clk);
      end
      rx = stop;
      repeat (CLK_DIV) @(negedge clk);
      rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   // Reference frame parser: predicts writes and header-time status.
   task automatic send_m(input logic [7:0] b);
      logic hdr;
      hdr = 1'b0;
      case (m_st)
         0: if (b == HDR) begin m_st = 1; m_addr = 8'd0; hdr = 1'b1; end
         1: begin m_cnt = (b == 8'd0) ? 256 : int'(b); m_st = 2; end
         2: begin
            exp_q.push_back({m_addr, b});
            m_addr = m_addr + 8'd1;
            m_cnt--;
            if (m_cnt == 0) m_st = 3;
         end
         default: m_st = 0;
      endcase
      send_byte(b, 1'b1);
      if (hdr) begin
         chk("hold_at_hdr", {31'd0, cpu_hold}, 32'd1);
         chk("err_clr_at_hdr", {31'd0, load_err}, 32'd0);
      end
   endtask

   task automatic chk_end(input string name, input int d0, input int exp_done,
                          input logic exp_err, input logic exp_hold);
      repeat (2) @(negedge clk);
      chk({name, "_done"}, done_cnt - d0, exp_done);
      chk({name, "_err"}, {31'd0, load_err}, {31'd0, exp_err});
      chk({name, "_hold"}, {31'd0, cpu_hold}, {31'd0, exp_hold});
      chk({name, "_sb_empty"}, exp_q.size(), 32'd0);
   endtask

   initial begin
      int d0;
      tbl[0].n = 6; tbl[0].b = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h9A, 8'h00, 8'h00};
      tbl[0].exp_done = 1; tbl[0].exp_err = 1'b0; tbl[0].exp_hold = 1'b0;
      tbl[1].n = 4; tbl[1].b = '{8'hA5, 8'h01, 8'h44, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[1].exp_done = 0; tbl[1].exp_err = 1'b1; tbl[1].exp_hold = 1'b1;
      tbl[2].n = 4; tbl[2].b = '{8'hA5, 8'h01, 8'h44, 8'hBC, 8'h00, 8'h00, 8'h00, 8'h00};
      tbl[2].exp_done = 1; tbl[2].exp_err = 1'b0; tbl[2].exp_hold = 1'b0;
      tbl[3].n = 8; tbl[3].b = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h02, 8'hA5, 8'h01, 8'h5A};
      tbl[3].exp_done = 1; tbl[3].exp_err = 1'b0; tbl[3].exp_hold = 1'b0;

      m_st = 0; m_addr = 8'd0; m_cnt = 0;
      rx = 1'b1;
      reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("reset_outputs", {12'd0, pm_wr_addr, pm_wr_data, pm_wren, cpu_hold, load_done, load_err}, 32'd0);
      reset = 1'b1;
      repeat (5) @(negedge clk);

      for (int r = 0; r < 4; r++) begin
         d0 = done_cnt;
         for (int k = 0; k < tbl[r].n; k++) send_m(tbl[r].b[k]);
         m_st = 0;
         chk_end($sformatf("row%0d", r), d0, tbl[r].exp_done, tbl[r].exp_err, tbl[r].exp_hold);
      end

      // Framing error in DATA: the bad byte must not be written.
      d0 = done_cnt;
      send_m(HDR); send_m(8'h03); send_m(8'h11);
      send_byte(8'h22, 1'b0);
      m_st = 0;
      chk_end("ferr", d0, 0, 1'b1, 1'b1);

      // One-cycle low glitch on an idle line.
      d0 = done_cnt;
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (12 * CLK_DIV) @(negedge clk);
      chk_end("glitch", d0, 0, 1'b1, 1'b1);

      // LEN=0: 256 bytes, value k at index k, checksum 0x80.
      d0 = done_cnt;
      send_m(HDR); send_m(8'h00);
      for (int k = 0; k < 256; k++) send_m(8'(k));
      send_m(8'h80);
      m_st = 0;
      chk_end("len0", d0, 1, 1'b0, 1'b0);
      chk("len0_last_write", {16'd0, last_addr, last_data}, 32'h0000FFFF);

      // Reset after 2 of 4 data bytes abandons the frame.
      send_m(HDR); send_m(8'h04); send_m(8'h01); send_m(8'h02);
      reset = 1'b0;
      repeat (2) @(negedge clk);
      chk("midreset_outputs", {12'd0, pm_wr_addr, pm_wr_data, pm_wren, cpu_hold, load_done, load_err}, 32'd0);
      reset = 1'b1;
      m_st = 0;
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      send_m(HDR); send_m(8'h01); send_m(8'h44); send_m(8'hBC);
      m_st = 0;
      chk_end("after_reset", d0, 1, 1'b0, 1'b0);

`ifdef PM_LOADER_TIMEOUT_EN
      d0 = done_cnt;
      send_m(HDR); send_m(8'h01);
      repeat (25 * CLK_DIV) @(negedge clk);
      m_st = 0;
      chk_end("timeout", d0, 0, 1'b1, 1'b1);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
